pipe_stage_buf: RTL

Parametrised pipeline-register stage for the pipelined CPU. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffers with one configurable block. The block carries a program counter, NUM_WORDS datapath words, a destination-register index and a control bundle between two stages. It adds a valid/ready handshake, an optional two-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter for performance monitoring.

---
 rtl/pipe_stage_buf_pkg.sv | 24 ++
 rtl/pipe_stage_buf_reg.sv | 42 ++++
 rtl/pipe_stage_buf.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the configurable pipeline-register stage: FSM
// encoding, control-bundle bit offsets and the NOP control value.
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Bit offsets of the fields inside the control bundle.
  typedef enum int {
    CTRL_REGWR  = 0,
    CTRL_MEMRD  = 1,
    CTRL_MEMWR  = 2,
    CTRL_BRANCH = 3,
    CTRL_ALUOP  = 4,
    CTRL_ALUSRC = 8
  } ctrl_bit_e;

  localparam int CTRL_MAX_W = 64;
  localparam logic [CTRL_MAX_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_buf_reg.sv
// One register slot of the stage: payload {pc, words, rd} with load enable,
// plus a control bundle that can additionally be cleared to NOP.
module pipe_stage_reg
  import pipe_stage_buf_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] d_data,
  input  logic [CW-1:0] d_ctrl,
  output logic [DW-1:0] q_data,
  output logic [CW-1:0] q_ctrl
);

  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] ctrl_q, ctrl_d;

  always_comb begin
    data_d = en ? d_data : data_q;
    ctrl_d = ctrl_q;
    if (clr)     ctrl_d = CTRL_NOP[CW-1:0];
    else if (en) ctrl_d = d_ctrl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign q_data = data_q;
  assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Configurable pipeline-register stage with valid/ready handshake, optional
// two-entry skid buffer, flush-to-bubble and a saturating stall counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int RD_W      = 6,
  parameter int CTRL_W    = 9,
  parameter bit SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_pc,
  input  logic [NUM_WORDS*DATA_W-1:0]   in_words,
  input  logic [RD_W-1:0]               in_rd,
  input  logic [CTRL_W-1:0]             in_ctrl,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_pc,
  output logic [NUM_WORDS*DATA_W-1:0]   out_words,
  output logic [RD_W-1:0]               out_rd,
  output logic [CTRL_W-1:0]             out_ctrl,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int DW = DATA_W + NUM_WORDS*DATA_W + RD_W;

  state_e      state_q, state_d;
  logic        acc, dlv;
  logic        head_en, skid_en, head_from_skid;
  logic [DW-1:0]     in_data, head_data, skid_data, head_d_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_d_ctrl;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign in_data   = {in_pc, in_words, in_rd};
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid && in_ready;
  assign dlv       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // With SKID=0 an accept in ONE always coincides with a deliver, so FULL
  // is unreachable and the same FSM serves both modes.
  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_EMPTY;
    else begin
      case (state_q)
        ST_EMPTY: if (acc) state_d = ST_ONE;
        ST_ONE: begin
          if (acc && !dlv)      state_d = ST_FULL;
          else if (!acc && dlv) state_d = ST_EMPTY;
        end
        ST_FULL:  if (dlv) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    head_en        = 1'b0;
    skid_en        = 1'b0;
    head_from_skid = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: head_en = acc;
        ST_ONE: begin
          head_en = acc && dlv;
          skid_en = acc && !dlv;
        end
        ST_FULL: begin
          head_en        = dlv;
          head_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign head_d_data = head_from_skid ? skid_data : in_data;
  assign head_d_ctrl = head_from_skid ? skid_ctrl : in_ctrl;

  pipe_stage_reg #(.DW(DW), .CW(CTRL_W)) u_head (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (head_en),
    .clr    (flush),
    .d_data (head_d_data),
    .d_ctrl (head_d_ctrl),
    .q_data (head_data),
    .q_ctrl (head_ctrl)
  );

  generate
    if (SKID) begin : g_skid
      logic rdy_q, rdy_d;

      pipe_stage_reg #(.DW(DW), .CW(CTRL_W)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (skid_en),
        .clr    (flush),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .q_data (skid_data),
        .q_ctrl (skid_ctrl)
      );

      // Registered ready: no combinational path from out_ready.
      assign rdy_d = (state_d != ST_FULL);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b1;
        else        rdy_q <= rdy_d;
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign skid_data = '0;
      assign skid_ctrl = '0;
      assign in_ready  = !out_valid || out_ready;
    end
  endgenerate

  assign {out_pc, out_words, out_rd} = head_data;
  assign out_ctrl = out_valid ? head_ctrl : CTRL_NOP[CTRL_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && !flush && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule
